// File: rtl/mac_array_seq.sv
// Job sequencer for the MAC tile array: tile reset, preload, execute and (OS only) psum flush.
// Optional MAC_ARRAY_SEQ_PERF_EN adds a saturating per-job stall counter output.
module mac_array_seq #(
   parameter int col    = 8,
   parameter int row    = 8,
   parameter int cnt_bw = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              is_os,
   input  logic              act_2b_mode,
   input  logic [cnt_bw-1:0] num_exec,
   input  logic              l0_valid,
   output logic              l0_rd,
   output logic              tile_reset,
   output logic [2:0]        inst_w,
   output logic              is_os_out,
   output logic              act_2b_out,
   output logic              busy,
`ifdef MAC_ARRAY_SEQ_PERF_EN
   output logic [15:0]       stall_cnt,
`endif
   output logic              done
);

   localparam int CNT_A   = $clog2(3*col + 1);
   localparam int CNT_B   = $clog2(row + col + 1);
   localparam int CNT_AB  = (CNT_A > CNT_B) ? CNT_A : CNT_B;
   localparam int CNT_W   = (CNT_AB > cnt_bw) ? CNT_AB : cnt_bw;
   localparam int FLUSH_N = row + col - 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_LOAD, S_GAP, S_EXEC, S_FLUSH, S_DONE
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [cnt_bw-1:0] r_num_exec;
   logic              r_is_os;
   logic              r_act_2b;
   logic              r_l0_rd;
   logic              r_tile_reset;
   logic [2:0]        r_inst;
   logic              r_busy;
   logic              r_done;

   logic [CNT_W-1:0]  w_load_len;
   logic [CNT_W-1:0]  w_exec_len;
   logic              w_slot;
   logic              w_slot_load;

`ifdef MAC_ARRAY_SEQ_PERF_EN
   logic [15:0]       r_stall_cnt;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign stall_cnt = r_stall_cnt;
`endif

   assign w_load_len = r_is_os  ? CNT_W'(row) :
                       r_act_2b ? CNT_W'(col) : CNT_W'(3*col);
   assign w_exec_len = CNT_W'(r_num_exec);

   // Next cycle is a LOAD/EXEC slot opportunity (issued or bubbled depending on l0_valid).
   assign w_slot_load = (r_state == S_CLR) || (r_state == S_LOAD && r_cnt != w_load_len);
   assign w_slot      = w_slot_load ||
                        (r_state == S_GAP  && w_exec_len != '0) ||
                        (r_state == S_EXEC && r_cnt != w_exec_len);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_num_exec   <= '0;
         r_is_os      <= 1'b0;
         r_act_2b     <= 1'b0;
         r_l0_rd      <= 1'b0;
         r_tile_reset <= 1'b0;
         r_inst       <= 3'b000;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
`ifdef MAC_ARRAY_SEQ_PERF_EN
         r_stall_cnt  <= '0;
`endif
      end else begin
         r_l0_rd      <= 1'b0;
         r_tile_reset <= 1'b0;
         r_inst       <= 3'b000;
         r_done       <= 1'b0;
         if (w_slot) begin
            r_state <= w_slot_load ? S_LOAD : S_EXEC;
            if (l0_valid) begin
               r_inst  <= w_slot_load ? 3'b001 : 3'b010;
               r_l0_rd <= 1'b1;
               r_cnt   <= r_cnt + 1'b1;
            end
`ifdef MAC_ARRAY_SEQ_PERF_EN
            else begin
               r_stall_cnt <= sat_inc16(r_stall_cnt);
            end
`endif
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_state      <= S_CLR;
                     r_is_os      <= is_os;
                     r_act_2b     <= act_2b_mode;
                     r_num_exec   <= num_exec;
                     r_cnt        <= '0;
                     r_busy       <= 1'b1;
                     r_tile_reset <= 1'b1;
`ifdef MAC_ARRAY_SEQ_PERF_EN
                     r_stall_cnt  <= '0;
`endif
                  end
               end
               S_LOAD: begin
                  r_state <= S_GAP;
                  r_cnt   <= '0;
               end
               S_GAP, S_EXEC: begin
                  // Execute finished (or empty): OS drains psums, WS completes directly.
                  if (r_is_os) begin
                     r_state <= S_FLUSH;
                     r_inst  <= 3'b100;
                     r_cnt   <= CNT_W'(1);
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_cnt   <= '0;
                  end
               end
               S_FLUSH: begin
                  if (r_cnt == CNT_W'(FLUSH_N)) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_cnt   <= '0;
                  end else begin
                     r_inst <= 3'b100;
                     r_cnt  <= r_cnt + 1'b1;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign l0_rd      = r_l0_rd;
   assign tile_reset = r_tile_reset;
   assign inst_w     = r_inst;
   assign is_os_out  = r_is_os;
   assign act_2b_out = r_act_2b;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_mac_array_seq.sv
// Directed bench for mac_array_seq: per-job cycle traces compared against hand-computed schedules.
module tb_mac_array_seq;

   logic        clk = 1'b0;
   logic        reset, start, is_os, act_2b_mode, l0_valid;
   logic [11:0] num_exec;
   logic        l0_rd, tile_reset, is_os_out, act_2b_out, busy, done;
   logic [2:0]  inst_w;
`ifdef MAC_ARRAY_SEQ_PERF_EN
   logic [15:0] stall_cnt;
`endif

   mac_array_seq #(.col(8), .row(8), .cnt_bw(12)) dut (
      .clk(clk), .reset(reset), .start(start), .is_os(is_os),
      .act_2b_mode(act_2b_mode), .num_exec(num_exec), .l0_valid(l0_valid),
      .l0_rd(l0_rd), .tile_reset(tile_reset), .inst_w(inst_w),
      .is_os_out(is_os_out), .act_2b_out(act_2b_out), .busy(busy),
`ifdef MAC_ARRAY_SEQ_PERF_EN
      .stall_cnt(stall_cnt),
`endif
      .done(done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   int n_load, n_exec, n_flush, n_rd, n_trst, trst_cyc, first_load;
   int done_cyc, n_done, rd_bad, os_bad, a2b_bad, busy_after;
   logic [2:0] hist [0:127];
   logic       busy_hist [0:127];

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Cycle 1 is the first cycle after the edge that accepts start.
   task automatic run_job(input logic m_os, input logic m_a2b, input int m_exec,
                          input int toggle, input int reset_at, input int start_at,
                          input int limit);
      n_load = 0; n_exec = 0; n_flush = 0; n_rd = 0; n_trst = 0; trst_cyc = 0;
      first_load = 0; done_cyc = 0; n_done = 0; rd_bad = 0; os_bad = 0;
      a2b_bad = 0; busy_after = -1;
      for (int i = 0; i < 128; i++) begin
         hist[i] = 3'b111;
         busy_hist[i] = 1'b1;
      end
      @(negedge clk);
      is_os = m_os; act_2b_mode = m_a2b; num_exec = m_exec[11:0];
      start = 1'b1; l0_valid = 1'b1;
      @(negedge clk);
      start = 1'b0; is_os = ~m_os; act_2b_mode = ~m_a2b;
      for (int cyc = 1; cyc <= limit; cyc++) begin
         hist[cyc]      = inst_w;
         busy_hist[cyc] = busy;
         if (tile_reset) begin
            n_trst++;
            if (trst_cyc == 0) trst_cyc = cyc;
         end
         if (inst_w == 3'b001) begin
            n_load++;
            if (first_load == 0) first_load = cyc;
         end
         if (inst_w == 3'b010) n_exec++;
         if (inst_w == 3'b100) n_flush++;
         if (l0_rd) n_rd++;
         if (l0_rd && inst_w != 3'b001 && inst_w != 3'b010) rd_bad++;
         if (busy && is_os_out != m_os) os_bad++;
         if (busy && act_2b_out != m_a2b) a2b_bad++;
         if (done) begin
            n_done++;
            if (done_cyc == 0) done_cyc = cyc;
         end
         if (done_cyc != 0 && cyc == done_cyc + 1) begin
            busy_after = int'(busy);
            break;
         end
         reset = (cyc == reset_at);
         start = (cyc == start_at);
         if (cyc == start_at) begin
            is_os = ~m_os; act_2b_mode = ~m_a2b; num_exec = 12'd1;
         end
         l0_valid = !(toggle != 0 && cyc >= 2 && cyc <= 24 && (cyc % 2) == 0);
         @(negedge clk);
      end
      reset = 1'b0; start = 1'b0; l0_valid = 1'b1;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; is_os = 1'b0; act_2b_mode = 1'b0;
      num_exec = '0; l0_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_inst", int'(inst_w), 0);
      chk("rst_rd", int'(l0_rd), 0);
      chk("rst_trst", int'(tile_reset), 0);
      chk("rst_os", int'(is_os_out), 0);
      chk("rst_a2b", int'(act_2b_out), 0);
      reset = 1'b0;

      // WS 4-bit, 5 exec cycles
      run_job(1'b0, 1'b0, 5, 0, 0, 0, 60);
      chk("ws4_trst_cyc", trst_cyc, 1);
      chk("ws4_trst_n", n_trst, 1);
      chk("ws4_first_load", first_load, 2);
      chk("ws4_load", n_load, 24);
      chk("ws4_gap", int'(hist[26]), 0);
      chk("ws4_exec", n_exec, 5);
      chk("ws4_flush", n_flush, 0);
      chk("ws4_done_cyc", done_cyc, 32);
      chk("ws4_done_n", n_done, 1);
      chk("ws4_rd", n_rd, 29);
      chk("ws4_rd_bad", rd_bad, 0);
      chk("ws4_busy_after", busy_after, 0);
`ifdef MAC_ARRAY_SEQ_PERF_EN
      chk("ws4_stall", int'(stall_cnt), 0);
`endif

      // WS 2-bit, start pulsed mid-job must be ignored
      run_job(1'b0, 1'b1, 3, 0, 0, 5, 60);
      chk("ws2_load", n_load, 8);
      chk("ws2_exec", n_exec, 3);
      chk("ws2_flush", n_flush, 0);
      chk("ws2_done_cyc", done_cyc, 14);
      chk("ws2_trst_n", n_trst, 1);
      chk("ws2_os_bad", os_bad, 0);
      chk("ws2_a2b_bad", a2b_bad, 0);

      // OS, 4 exec cycles
      run_job(1'b1, 1'b0, 4, 0, 0, 0, 60);
      chk("os_load", n_load, 8);
      chk("os_gap", int'(hist[10]), 0);
      chk("os_exec_first", int'(hist[11]), 2);
      chk("os_exec", n_exec, 4);
      chk("os_flush", n_flush, 15);
      chk("os_flush_first", int'(hist[15]), 4);
      chk("os_done_cyc", done_cyc, 30);
      chk("os_rd", n_rd, 12);
      chk("os_os_bad", os_bad, 0);

      // WS 4-bit with l0_valid toggling during LOAD
      run_job(1'b0, 1'b0, 5, 1, 0, 0, 80);
      chk("tog_slot2", int'(hist[2]), 1);
      chk("tog_bubble3", int'(hist[3]), 0);
      chk("tog_slot4", int'(hist[4]), 1);
      chk("tog_load", n_load, 24);
      chk("tog_rd", n_rd, 29);
      chk("tog_rd_bad", rd_bad, 0);
      chk("tog_done_cyc", done_cyc, 44);
`ifdef MAC_ARRAY_SEQ_PERF_EN
      chk("tog_stall", int'(stall_cnt), 12);
`endif

      // OS with num_exec = 0
      run_job(1'b1, 1'b0, 0, 0, 0, 0, 60);
      chk("os0_exec", n_exec, 0);
      chk("os0_gap", int'(hist[10]), 0);
      chk("os0_flush_first", int'(hist[11]), 4);
      chk("os0_flush", n_flush, 15);
      chk("os0_done_cyc", done_cyc, 26);

      // Reset asserted mid-EXEC
      run_job(1'b0, 1'b1, 10, 0, 13, 0, 16);
      chk("rstx_exec", n_exec, 3);
      chk("rstx_busy", int'(busy_hist[14]), 0);
      chk("rstx_inst", int'(hist[14]), 0);
      chk("rstx_done_n", n_done, 0);
      chk("rstx_trst_n", n_trst, 1);

      // New job accepted right after the reset
      run_job(1'b0, 1'b1, 3, 0, 0, 0, 60);
      chk("post_trst_cyc", trst_cyc, 1);
      chk("post_load", n_load, 8);
      chk("post_done_cyc", done_cyc, 14);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
